// File: rtl/sram_bank_arb.sv
// Multi-port OBI front end for a row of single-port SRAM macros: per-bank round-robin
// arbitration, immediate error responses for bad requests, and first-error capture.

// Behavioural stand-in for the sky130 1rw1r macro: port 0 read/write, port 1 read-only,
// registered read on both ports.
module sky130_sram_2kbyte_1rw1r_32x512_8 #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_DEPTH  = 512,
  parameter int DELAY      = 3
) (
`ifdef USE_POWER_PINS
  inout  wire                    vccd1,
  inout  wire                    vssd1,
`endif
  input  logic                   clk0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [NUM_WMASKS-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   clk1,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1
);

  // One byte-wide array per write-mask lane keeps byte writes simple for RAM inference.
  for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_lane
    logic [7:0] mem [RAM_DEPTH];
    logic [7:0] rd0_q;
    logic [7:0] rd1_q;

    always_ff @(posedge clk0) begin
      if (!csb0 && !web0 && wmask0[gi]) begin
        mem[addr0] <= din0[8*gi +: 8];
      end
      if (!csb0 && web0) begin
        rd0_q <= mem[addr0];
      end
    end

    always_ff @(posedge clk1) begin
      if (!csb1) begin
        rd1_q <= mem[addr1];
      end
    end

    assign dout0[8*gi +: 8] = rd0_q;
    assign dout1[8*gi +: 8] = rd1_q;
  end

endmodule

module sram_bank_arb #(
  parameter int                   NUM_PORTS    = 3,
  parameter int                   NUM_BANKS    = 10,
  parameter int                   BANK_WORDS   = 512,
  parameter logic [31:0]          BASE_ADDR    = 32'h8000_0000,
  parameter logic [NUM_PORTS-1:0] RO_PORT_MASK = NUM_PORTS'(1)
) (
`ifdef USE_POWER_PINS
  inout  wire                      vccd1,
  inout  wire                      vssd1,
`endif
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_PORTS-1:0]     req_i,
  output logic [NUM_PORTS-1:0]     gnt_o,
  input  logic [NUM_PORTS*32-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]     we_i,
  input  logic [NUM_PORTS*4-1:0]   be_i,
  input  logic [NUM_PORTS*32-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]     rvalid_o,
  output logic [NUM_PORTS*32-1:0]  rdata_o,
  output logic [NUM_PORTS-1:0]     err_o,
  input  logic                     err_clr_i,
  output logic                     err_sticky_o,
  output logic [31:0]              err_addr_o,
  output logic [2:0]               err_port_o
);

  localparam int          AW       = $clog2(BANK_WORDS);
  localparam int          BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int          PW       = $clog2(NUM_PORTS);
  localparam logic [32:0] END_OFF  = 33'(NUM_BANKS * BANK_WORDS * 4);
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic [NUM_PORTS-1:0] legal;
  logic [NUM_PORTS-1:0] legal_req;
  logic [NUM_PORTS-1:0] won;
  logic [NUM_PORTS-1:0] gnt;
  logic [BW-1:0]        port_bank [NUM_PORTS];
  logic [AW-1:0]        port_word [NUM_PORTS];
  logic [NUM_PORTS-1:0] bank_gnt  [NUM_BANKS];
  logic [31:0]          bank_dout [NUM_BANKS];

  logic [NUM_PORTS-1:0] rvalid_q;
  logic [NUM_PORTS-1:0] err_q;
  logic [NUM_PORTS-1:0] we_q;
  logic [BW-1:0]        bank_q [NUM_PORTS];
  logic [31:0]          addr_q [NUM_PORTS];

  logic                 sticky_q, sticky_d;
  logic [31:0]          err_addr_q, err_addr_d;
  logic [2:0]           err_port_q, err_port_d;
  logic [NUM_PORTS-1:0] err_resp;

  always_comb begin
    logic [31:0] paddr;
    logic [31:0] poff;
    paddr = '0;
    poff  = '0;
    legal = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      paddr        = addr_i[32*p +: 32];
      poff         = paddr - BASE_ADDR;
      legal[p]     = (paddr >= BASE_ADDR) && ({1'b0, poff} < END_OFF) &&
                     (paddr[1:0] == 2'b00) && !(we_i[p] && RO_PORT_MASK[p]);
      port_bank[p] = BW'(poff >> (AW + 2));
      port_word[p] = poff[AW+1:2];
    end
  end

  assign legal_req = req_i & legal & ~{NUM_PORTS{rst_i}};

  always_comb begin
    won = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      won = won | bank_gnt[b];
    end
  end

  // Illegal requests are accepted at once; legal ones only when their bank picks them.
  assign gnt   = req_i & ~{NUM_PORTS{rst_i}} & (~legal | won);
  assign gnt_o = gnt;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic [31:0]   dout1_unused;

    always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_PORTS) begin
          idx = idx - NUM_PORTS;
        end
        if (!win_found && legal_req[idx] && (port_bank[idx] == BW'(gi))) begin
          win_found = 1'b1;
          win_idx   = PW'(idx);
        end
      end
    end

    always_comb begin
      ptr_d = ptr_q;
      if (win_found) begin
        ptr_d = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end

    assign bank_gnt[gi] = win_found ? (NUM_PORTS'(1) << win_idx) : '0;

    sky130_sram_2kbyte_1rw1r_32x512_8 #(
      .DELAY(0)
    ) u_macro (
`ifdef USE_POWER_PINS
      .vccd1  (vccd1),
      .vssd1  (vssd1),
`endif
      .clk0   (clk_i),
      .csb0   (~win_found),
      .web0   (~we_i[win_idx]),
      .wmask0 (be_i[4*win_idx +: 4]),
      .addr0  (9'(port_word[win_idx])),
      .din0   (wdata_i[32*win_idx +: 32]),
      .dout0  (bank_dout[gi]),
      .clk1   (clk_i),
      .csb1   (1'b1),
      .addr1  (9'd0),
      .dout1  (dout1_unused)
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      err_q    <= '0;
      we_q     <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        bank_q[p] <= '0;
        addr_q[p] <= '0;
      end
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & ~legal;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt[p]) begin
          we_q[p]   <= we_i[p];
          bank_q[p] <= port_bank[p];
          addr_q[p] <= addr_i[32*p +: 32];
        end
      end
    end
  end

  // Responses are masked while reset is held so nothing in flight leaks out.
  assign rvalid_o = rvalid_q & ~{NUM_PORTS{rst_i}};
  assign err_o    = rvalid_q & err_q & ~{NUM_PORTS{rst_i}};
  assign err_resp = rvalid_q & err_q;

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rvalid_o[p]) begin
        if (err_q[p]) begin
          rdata_o[32*p +: 32] = ERR_DATA;
        end else if (!we_q[p]) begin
          rdata_o[32*p +: 32] = bank_dout[bank_q[p]];
        end
      end
    end
  end

  always_comb begin
    logic        found;
    logic [2:0]  cap_port;
    logic [31:0] cap_addr;
    found      = 1'b0;
    cap_port   = '0;
    cap_addr   = '0;
    sticky_d   = sticky_q;
    err_addr_d = err_addr_q;
    err_port_d = err_port_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found && err_resp[p]) begin
        found    = 1'b1;
        cap_port = 3'(p);
        cap_addr = addr_q[p];
      end
    end
    // A clear coinciding with a new error response still records that error.
    if (found && (!sticky_q || err_clr_i)) begin
      sticky_d   = 1'b1;
      err_addr_d = cap_addr;
      err_port_d = cap_port;
    end else if (err_clr_i) begin
      sticky_d   = 1'b0;
      err_addr_d = '0;
      err_port_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
      err_port_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
      err_port_q <= err_port_d;
    end
  end

  assign err_sticky_o = sticky_q;
  assign err_addr_o   = err_addr_q;
  assign err_port_o   = err_port_q;

endmodule

// File: tb/tb_sram_bank_arb.sv
// Directed bench for sram_bank_arb: single-port transaction table plus hand-written
// sequences for collisions, sticky error capture and mid-flight reset.
module tb_sram_bank_arb;

  localparam int NP = 3;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [NP-1:0]   req_i = '0;
  logic [NP-1:0]   we_i = '0;
  logic [NP*32-1:0] addr_i = '0;
  logic [NP*32-1:0] wdata_i = '0;
  logic [NP*4-1:0] be_i = '0;
  logic            err_clr_i = 1'b0;
  logic [NP-1:0]   gnt_o;
  logic [NP-1:0]   rvalid_o;
  logic [NP-1:0]   err_o;
  logic [NP*32-1:0] rdata_o;
  logic            err_sticky_o;
  logic [31:0]     err_addr_o;
  logic [2:0]      err_port_o;

  int n_chk = 0;
  int n_fail = 0;

  sram_bank_arb dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i),
    .err_sticky_o (err_sticky_o),
    .err_addr_o   (err_addr_o),
    .err_port_o   (err_port_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] be, input logic [31:0] wd);
    req_i[p]            = 1'b1;
    addr_i[32*p +: 32]  = a;
    we_i[p]             = w;
    be_i[4*p +: 4]      = be;
    wdata_i[32*p +: 32] = wd;
  endtask

  task automatic clr_port(input int p);
    req_i[p] = 1'b0;
    we_i[p]  = 1'b0;
  endtask

  task automatic check_sticky(input string tag, input logic s, input logic [31:0] a,
                              input logic [2:0] p);
    chk({tag, "_sticky"}, 32'(err_sticky_o), 32'(s));
    chk({tag, "_addr"}, err_addr_o, a);
    chk({tag, "_port"}, 32'(err_port_o), 32'(p));
  endtask

  // One uncontended request: grant in the request cycle, response one cycle later.
  task automatic xact(input int p, input logic [31:0] a, input logic w, input logic [3:0] be,
                      input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                      input string tag);
    @(negedge clk);
    set_port(p, a, w, be, wd);
    #1;
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(NP'(1) << p));
    @(posedge clk);
    #1;
    clr_port(p);
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'(NP'(1) << p));
    chk({tag, "_err"}, 32'(err_o), 32'(NP'(exp_err) << p));
    chk({tag, "_rdata"}, rdata_o[32*p +: 32], exp_rd);
    $display("xact %s port %0d addr %h we %0d rdata %h err %0d", tag, p, a, w,
             rdata_o[32*p +: 32], err_o[p]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NP-1:0] exp_g [3];

    vecs[0]  = '{1, 32'h8000_0804, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1, 32'h8000_0804, 1'b0, 4'hF, 32'h0,         1'b0, 32'h1234_5678};
    vecs[2]  = '{2, 32'h8000_4FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[3]  = '{2, 32'h8000_4FFC, 1'b0, 4'hF, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[4]  = '{1, 32'h8000_5000, 1'b0, 4'hF, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1, 32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{2, 32'h8000_0002, 1'b0, 4'hF, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{2, 32'h8000_0010, 1'b1, 4'hF, 32'hAABB_CCDD, 1'b0, 32'h0000_0000};
    vecs[8]  = '{0, 32'h8000_0010, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{2, 32'h8000_0010, 1'b1, 4'h5, 32'h1122_3344, 1'b0, 32'h0000_0000};
    vecs[10] = '{0, 32'h8000_0010, 1'b0, 4'hF, 32'h0,         1'b0, 32'hAA22_CC44};
    vecs[11] = '{1, 32'h8000_0010, 1'b0, 4'hF, 32'h0,         1'b0, 32'hAA22_CC44};
    vecs[12] = '{0, 32'h8000_0804, 1'b0, 4'hF, 32'h0,         1'b0, 32'h1234_5678};
    vecs[13] = '{1, 32'h8000_1800, 1'b1, 4'hF, 32'h3333_0000, 1'b0, 32'h0000_0000};
    vecs[14] = '{1, 32'h8000_1804, 1'b1, 4'hF, 32'h3333_0004, 1'b0, 32'h0000_0000};
    vecs[15] = '{1, 32'h8000_1800, 1'b0, 4'hF, 32'h0,         1'b0, 32'h3333_0000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    for (int p = 0; p < NP; p++) chk("rst_rdata", rdata_o[32*p +: 32], 32'h0);
    check_sticky("rst", 1'b0, 32'h0, 3'd0);

    // Two ports on different banks are granted together
    @(negedge clk);
    set_port(0, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    set_port(1, 32'h8000_0808, 1'b1, 4'hF, 32'h5555_AAAA);
    #1;
    chk("dual_gnt", 32'(gnt_o), 32'h3);
    @(posedge clk);
    #1;
    clr_port(0);
    clr_port(1);
    chk("dual_rvalid", 32'(rvalid_o), 32'h3);
    chk("dual_err", 32'(err_o), 32'h0);
    chk("dual_wr_rdata", rdata_o[63:32], 32'h0);
    $display("xact dual p0 rd 80000000 p1 wr 80000808 rvalid %b", rvalid_o);
    xact(1, 32'h8000_0808, 1'b0, 4'hF, 32'h0, 1'b0, 32'h5555_AAAA, "dual_rb");

    for (int i = 0; i < 16; i++) begin
      xact(vecs[i].port, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
           vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // First error of the table was port 1 at END
    @(negedge clk);
    check_sticky("tbl", 1'b1, 32'h8000_5000, 3'd1);
    err_clr_i = 1'b1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    check_sticky("clr1", 1'b0, 32'h0, 3'd0);

    // Simultaneous errors: lowest port index is captured
    @(negedge clk);
    set_port(1, 32'h8000_0001, 1'b0, 4'hF, 32'h0);
    set_port(2, 32'h9000_0000, 1'b0, 4'hF, 32'h0);
    #1;
    chk("dual_err_gnt", 32'(gnt_o), 32'h6);
    @(posedge clk);
    #1;
    clr_port(1);
    clr_port(2);
    chk("dual_err_resp", 32'(err_o), 32'h6);
    chk("dual_err_rdata2", rdata_o[95:64], 32'hDEAD_BEEF);
    $display("xact simultaneous errors p1/p2 err %b", err_o);
    @(posedge clk);
    #1;
    check_sticky("simul", 1'b1, 32'h8000_0001, 3'd1);

    // Clear in the same cycle as an error response: the new error is captured
    @(negedge clk);
    set_port(2, 32'h8000_000A, 1'b0, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    clr_port(2);
    err_clr_i = 1'b1;
    chk("clr_err_resp", 32'(err_o), 32'h4);
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    check_sticky("clr_cap", 1'b1, 32'h8000_000A, 3'd2);
    $display("xact clear with concurrent error p2 captured port %0d", err_port_o);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    check_sticky("clr2", 1'b0, 32'h0, 3'd0);

    // Recapture after clear (read-only port write)
    xact(0, 32'h8000_0020, 1'b1, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, "ro_wr");
    @(posedge clk);
    #1;
    check_sticky("recap", 1'b1, 32'h8000_0020, 3'd0);

    // Reset in the cycle after a grant drops the responses
    @(negedge clk);
    set_port(0, 32'h8000_0804, 1'b0, 4'hF, 32'h0);
    set_port(2, 32'h8000_0003, 1'b0, 4'hF, 32'h0);
    #1;
    chk("prerst_gnt", 32'(gnt_o), 32'h5);
    @(posedge clk);
    #1;
    clr_port(0);
    clr_port(2);
    rst_i = 1'b1;
    set_port(1, 32'h8000_1800, 1'b0, 4'hF, 32'h0);
    #1;
    chk("inrst_gnt", 32'(gnt_o), 32'h0);
    chk("inrst_rvalid", 32'(rvalid_o), 32'h0);
    chk("inrst_err", 32'(err_o), 32'h0);
    for (int p = 0; p < NP; p++) chk("inrst_rdata", rdata_o[32*p +: 32], 32'h0);
    @(posedge clk);
    #1;
    check_sticky("postrst", 1'b0, 32'h0, 3'd0);
    chk("postrst_rvalid", 32'(rvalid_o), 32'h0);
    $display("xact reset after grant rvalid %b sticky %0d", rvalid_o, err_sticky_o);
    @(negedge clk);
    rst_i = 1'b0;
    clr_port(1);

    // Bank 3 collision between ports 1 and 2 with pointer back at 0
    exp_g[0] = 3'b010;
    exp_g[1] = 3'b100;
    exp_g[2] = 3'b010;
    @(negedge clk);
    set_port(1, 32'h8000_1800, 1'b0, 4'hF, 32'h0);
    set_port(2, 32'h8000_1804, 1'b0, 4'hF, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rr%0d_gnt", c), 32'(gnt_o), 32'(exp_g[c]));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_rvalid", c), 32'(rvalid_o), 32'(exp_g[c]));
      chk($sformatf("rr%0d_err", c), 32'(err_o), 32'h0);
      if (exp_g[c][1]) begin
        chk($sformatf("rr%0d_rdata1", c), rdata_o[63:32], 32'h3333_0000);
        chk($sformatf("rr%0d_rdata2", c), rdata_o[95:64], 32'h0);
      end else begin
        chk($sformatf("rr%0d_rdata2", c), rdata_o[95:64], 32'h3333_0004);
        chk($sformatf("rr%0d_rdata1", c), rdata_o[63:32], 32'h0);
      end
      $display("xact rr cycle %0d gnt %b rvalid %b", c, exp_g[c], rvalid_o);
      if (c == 2) begin
        clr_port(1);
        clr_port(2);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("rr_tail_rvalid", 32'(rvalid_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
